// File: rtl/ldpc_frame_engine.sv
// ldpc_frame_engine
// Multi-frame stimulus/check engine for the LDPC decoder.
//   Feed side : reads FRAME_LEN soft LLRs per frame from an external LLR
//               memory (1-cycle read latency) and streams them to the decoder
//               on data_in/sync_in, waiting for dec_busy low before each frame
//               and inserting gap_cycles idle cycles between frames.
//   Check side: compares every decoded bit against a golden-bit memory
//               (1-cycle read latency), counts bit errors, errored frames,
//               received frames and the highest iteration count reported.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             pulse: latch config, clear statistics, begin a run
//   num_frames, gap_cycles, rate_cfg, max_iter_cfg   run configuration
//   llr_rd_en/llr_frm/llr_addr/llr_rd_data           LLR memory port
//   data_in/sync_in/rate/max_iter                    decoder input side
//   dec_data_out/dec_sync_out/dec_busy/dec_num_iter  decoder output side
//   gold_rd_en/gold_frm/gold_addr/gold_bit           golden memory port
//   active/done/timeout                              run status
//   bit_err_cnt/frm_err_cnt/frm_rx_cnt/max_iter_seen statistics
//   state_dbg                                        current FSM state
// Handshake: the decoder is only offered a new frame while dec_busy is low;
// sync_in is held high for exactly FRAME_LEN contiguous cycles per frame, and
// a decoded frame is the contiguous run of cycles with dec_sync_out high.
module ldpc_frame_engine #(
    parameter int D_WID     = 6,
    parameter int FRAME_LEN = 9216,
    parameter int K_R12     = 4608,
    parameter int K_R34     = 6912,
    parameter int A_WID     = 14,
    parameter int F_WID     = 8,
    parameter int G_WID     = 16,
    parameter int E_WID     = 24,
    parameter int TIMEOUT   = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [F_WID-1:0] num_frames,
    input  logic [G_WID-1:0] gap_cycles,
    input  logic             rate_cfg,
    input  logic [4:0]       max_iter_cfg,
    output logic             llr_rd_en,
    output logic [F_WID-1:0] llr_frm,
    output logic [A_WID-1:0] llr_addr,
    input  logic [D_WID-1:0] llr_rd_data,
    output logic [D_WID-1:0] data_in,
    output logic             sync_in,
    output logic             rate,
    output logic [4:0]       max_iter,
    input  logic             dec_data_out,
    input  logic             dec_sync_out,
    input  logic             dec_busy,
    input  logic [4:0]       dec_num_iter,
    output logic             gold_rd_en,
    output logic [F_WID-1:0] gold_frm,
    output logic [A_WID-1:0] gold_addr,
    input  logic             gold_bit,
    output logic             active,
    output logic             done,
    output logic             timeout,
    output logic [E_WID-1:0] bit_err_cnt,
    output logic [F_WID-1:0] frm_err_cnt,
    output logic [F_WID-1:0] frm_rx_cnt,
    output logic [4:0]       max_iter_seen,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BUSY = 3'd1,
        S_SEND      = 3'd2,
        S_GAP       = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [A_WID-1:0] LAST_ADDR = A_WID'(FRAME_LEN - 1);
    localparam logic [A_WID:0]   K12       = (A_WID+1)'(K_R12);
    localparam logic [A_WID:0]   K34       = (A_WID+1)'(K_R34);
    localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [F_WID-1:0] num_frames_q;
    logic [G_WID-1:0] gap_q;
    logic [F_WID-1:0] tx_idx;
    logic [F_WID-1:0] tx_next;
    logic [A_WID-1:0] rd_addr;
    logic [G_WID-1:0] gap_cnt;
    logic [31:0]      idle_cnt;
    logic             rd_vld;

    // checker state; bit_cnt is one bit wider so over-long frames still count
    logic             dec_d;
    logic             cmp_vld;
    logic             sync_d;
    logic             frm_bad;
    logic [A_WID:0]   bit_cnt;
    logic [A_WID:0]   k_exp;

    logic start_ok, send_last, rx_all, drain_timeout;
    logic chk_on, cmp_err, frm_end, len_err;

    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign send_last = (state == S_SEND) && (rd_addr == LAST_ADDR);
    assign tx_next   = tx_idx + F_WID'(1);
    assign rx_all    = (frm_rx_cnt == num_frames_q);
    assign drain_timeout = (state == S_DRAIN) && !rx_all && !dec_sync_out &&
                           (idle_cnt == TO_LAST);

    // next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        llr_rd_en = 1'b0;
        active    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start_ok)
                    state_nxt = (num_frames == '0) ? S_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                active = 1'b1;
                if (!dec_busy) state_nxt = S_SEND;
            end
            S_SEND: begin
                active    = 1'b1;
                llr_rd_en = 1'b1;
                if (send_last) begin
                    if (tx_next == num_frames_q) state_nxt = S_DRAIN;
                    else if (gap_q == '0)        state_nxt = S_WAIT_BUSY;
                    else                         state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                active = 1'b1;
                if (gap_cnt == gap_q - G_WID'(1)) state_nxt = S_WAIT_BUSY;
            end
            S_DRAIN: begin
                active = 1'b1;
                if (rx_all || drain_timeout) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign llr_addr  = rd_addr;
    assign llr_frm   = tx_idx;
    assign state_dbg = state;

    // run control: configuration, frame/address sequencing, gap and idle timers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            num_frames_q <= '0;
            gap_q        <= '0;
            rate         <= 1'b0;
            max_iter     <= '0;
            tx_idx       <= '0;
            rd_addr      <= '0;
            gap_cnt      <= '0;
            idle_cnt     <= '0;
            timeout      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                num_frames_q <= num_frames;
                gap_q        <= gap_cycles;
                rate         <= rate_cfg;
                max_iter     <= max_iter_cfg;
                timeout      <= 1'b0;
                tx_idx       <= '0;
                rd_addr      <= '0;
            end
            if (state == S_SEND) begin
                if (send_last) begin
                    rd_addr <= '0;
                    tx_idx  <= tx_next;
                end else begin
                    rd_addr <= rd_addr + A_WID'(1);
                end
            end
            gap_cnt  <= (state == S_GAP) ? gap_cnt + G_WID'(1) : '0;
            // any decoded bit restarts the drain watchdog
            idle_cnt <= (state == S_DRAIN && !dec_sync_out) ? idle_cnt + 32'd1 : '0;
            if (drain_timeout) timeout <= 1'b1;
        end
    end

    // feed pipeline: read data arrives the cycle after the strobe and is
    // registered together with its sync flag so data_in and sync_in align
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld  <= 1'b0;
            sync_in <= 1'b0;
            data_in <= '0;
        end else begin
            rd_vld  <= llr_rd_en;
            sync_in <= rd_vld;
            data_in <= rd_vld ? llr_rd_data : '0;
        end
    end

    // checker
    assign chk_on     = (state != S_IDLE);
    assign k_exp      = rate ? K34 : K12;
    assign gold_rd_en = chk_on && dec_sync_out && (bit_cnt < k_exp);
    assign gold_addr  = bit_cnt[A_WID-1:0];
    assign gold_frm   = frm_rx_cnt;
    assign cmp_err    = cmp_vld && (dec_d != gold_bit);
    assign frm_end    = sync_d && !dec_sync_out;
    assign len_err    = (bit_cnt != k_exp);

    // the compare of a frame's last in-range bit lands in the same cycle as
    // the frame end, so cmp_err is folded into the frame verdict directly
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            dec_d         <= 1'b0;
            cmp_vld       <= 1'b0;
            sync_d        <= 1'b0;
            frm_bad       <= 1'b0;
            bit_cnt       <= '0;
            bit_err_cnt   <= '0;
            frm_err_cnt   <= '0;
            frm_rx_cnt    <= '0;
            max_iter_seen <= '0;
        end else begin
            dec_d   <= dec_data_out;
            cmp_vld <= gold_rd_en;
            sync_d  <= chk_on && dec_sync_out;
            if (cmp_err && ~&bit_err_cnt) bit_err_cnt <= bit_err_cnt + E_WID'(1);
            if (frm_end) begin
                bit_cnt <= '0;
                frm_bad <= 1'b0;
                if (~&frm_rx_cnt) frm_rx_cnt <= frm_rx_cnt + F_WID'(1);
                if ((frm_bad || cmp_err || len_err) && ~&frm_err_cnt)
                    frm_err_cnt <= frm_err_cnt + F_WID'(1);
                if (dec_num_iter > max_iter_seen) max_iter_seen <= dec_num_iter;
            end else begin
                if (chk_on && dec_sync_out && ~&bit_cnt) bit_cnt <= bit_cnt + (A_WID+1)'(1);
                if (cmp_err) frm_bad <= 1'b1;
            end
        end
    end

endmodule
